// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: memory, decode control and fetch/decode register signals.
// The master side is the fetch stage; the slave side is memory plus decode.
interface fetch_stage_if;
    logic [15:0] Instruction;
    logic        Stall;
    logic        Redirect;
    logic [15:0] RedirectTarget;
    logic        Halt;
    logic [15:0] PC;
    logic [15:0] IR;
    logic [15:0] IR_PC;
    logic        IR_Valid;
    logic        Halted;
    logic [15:0] FetchCount;

    modport master (
        input  Instruction, Stall, Redirect, RedirectTarget, Halt,
        output PC, IR, IR_PC, IR_Valid, Halted, FetchCount
    );

    modport slave (
        output Instruction, Stall, Redirect, RedirectTarget, Halt,
        input  PC, IR, IR_PC, IR_Valid, Halted, FetchCount
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, latches memory words into IR,
// and handles stall, redirect and halt requests coming from decode.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'd0
) (
    input  logic          Clock,
    input  logic          Reset,
    fetch_stage_if.master bus
);

    typedef enum logic [1:0] {
        START  = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [15:0] RESET_PC_ALIGNED = {RESET_PC[15:1], 1'b0};

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic [15:0] count_q, count_d;

    // Next-state logic: one action per RUN edge, halt > redirect > stall > advance.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        count_d    = count_q;
        unique case (state_q)
            START: begin
                state_d = RUN;
            end
            RUN: begin
                if (bus.Halt) begin
                    state_d    = HALTED;
                    ir_valid_d = 1'b0;
                end else if (bus.Redirect) begin
                    pc_d       = bus.RedirectTarget & 16'hFFFE;
                    ir_d       = 16'h0000;
                    ir_valid_d = 1'b0;
                end else if (!bus.Stall) begin
                    ir_d       = bus.Instruction;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + 16'd2;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                end
            end
            HALTED: begin
                ir_valid_d = 1'b0;
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    // State and pipeline registers, cleared asynchronously by Reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= START;
            pc_q       <= RESET_PC_ALIGNED;
            ir_q       <= 16'h0000;
            ir_pc_q    <= 16'h0000;
            ir_valid_q <= 1'b0;
            count_q    <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            count_q    <= count_d;
        end
    end

    assign bus.PC         = pc_q;
    assign bus.IR         = ir_q;
    assign bus.IR_PC      = ir_pc_q;
    assign bus.IR_Valid   = ir_valid_q;
    assign bus.Halted     = (state_q == HALTED);
    assign bus.FetchCount = count_q;

endmodule
